// File: rtl/mem_access_unit_pkg.sv
// Shared constants for the memory access unit: FSM state encoding, error codes
// and default bus widths.
package mem_access_unit_pkg;

    localparam int DEF_AW = 8;
    localparam int DEF_DW = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_RANGE   = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/acknowledge memory port between the access unit (master) and the RAM (slave).
interface mem_access_unit_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/mem_access_unit_timeout_counter.sv
// Bus timeout timer: down-counter reloaded while cleared, flags expiry on the
// TIMEOUT-th enabled cycle (terminal count reached).
module timeout_counter #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LOAD = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= LOAD;
        end else if (clear) begin
            cnt <= LOAD;
        end else if (enable && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Terminal count: this is the last cycle the request may wait for an ack.
    assign expired = (cnt == '0);

endmodule

// File: rtl/mem_access_unit.sv
// Memory access unit: MAR/MDR register pair driving one read or write transaction
// on a req/ack memory port, with range check, auto-increment and bus timeout.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW,
    parameter int DEPTH   = 256,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          we,
    input  logic          incr,
    input  logic [AW-1:0] addr_in,
    input  logic [DW-1:0] wdata,
    output logic          busy,
    output logic          done,
    output logic [1:0]    err,
    output logic [AW-1:0] mar_out,
    output logic [DW-1:0] mdr_out,
    mem_access_unit_if.master mem
);

    localparam logic [AW:0]   LIMIT = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);

    logic [1:0]    state;
    logic [AW-1:0] mar;
    logic [DW-1:0] mdr;
    logic [DW-1:0] wdata_q;
    logic          req_q;
    logic          we_q;
    logic [1:0]    err_q;
    logic [AW-1:0] sel_addr;
    logic          in_range;
    logic          expired;

    always_comb begin
        sel_addr = addr_in;
        if (incr) begin
            sel_addr = (mar == LAST) ? '0 : mar + 1'b1;
        end
        in_range = ({1'b0, sel_addr} < LIMIT);
    end

    timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (state != ST_REQ),
        .enable  ((state == ST_REQ) && !mem.mem_ack),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            mar     <= '0;
            mdr     <= '0;
            wdata_q <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= ERR_OK;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        mar     <= sel_addr;
                        wdata_q <= wdata;
                        if (in_range) begin
                            err_q <= ERR_OK;
                            req_q <= 1'b1;
                            we_q  <= we;
                            state <= ST_REQ;
                        end else begin
                            err_q <= ERR_RANGE;
                            state <= ST_DONE;
                        end
                    end
                end
                ST_REQ: begin
                    // Ack takes priority over a timeout landing on the same edge.
                    if (mem.mem_ack) begin
                        if (!we_q) begin
                            mdr <= mem.mem_rdata;
                        end
                        req_q <= 1'b0;
                        we_q  <= 1'b0;
                        state <= ST_DONE;
                    end else if (expired) begin
                        req_q <= 1'b0;
                        we_q  <= 1'b0;
                        err_q <= ERR_TIMEOUT;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy          = (state != ST_IDLE);
    assign done          = (state == ST_DONE);
    assign err           = err_q;
    assign mar_out       = mar;
    assign mdr_out       = mdr;
    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = mar;
    assign mem.mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit (DEPTH=200, TIMEOUT=4) with hand-computed expectations.
module tb_mem_access_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       we;
    logic       incr;
    logic [7:0] addr_in;
    logic [7:0] wdata;
    logic       busy;
    logic       done;
    logic [1:0] err;
    logic [7:0] mar_out;
    logic [7:0] mdr_out;

    int vectors = 0;
    int miscompares = 0;

    mem_access_unit_if #(.AW(8), .DW(8)) bus ();

    mem_access_unit #(
        .AW      (8),
        .DW      (8),
        .DEPTH   (200),
        .TIMEOUT (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .we      (we),
        .incr    (incr),
        .addr_in (addr_in),
        .wdata   (wdata),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .mar_out (mar_out),
        .mdr_out (mdr_out),
        .mem     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; we = 1'b0; incr = 1'b0;
        addr_in = '0; wdata = '0;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req",   32'(bus.mem_req), 0);
        check("rst_we",    32'(bus.mem_we), 0);
        check("rst_busy",  32'(busy), 0);
        check("rst_done",  32'(done), 0);
        check("rst_err",   32'(err), 0);
        check("rst_mar",   32'(mar_out), 0);
        check("rst_mdr",   32'(mdr_out), 0);
        check("rst_wdata", 32'(bus.mem_wdata), 0);
        rst = 1'b0;
        tick();

        // Read 0x10, ack in first REQ cycle -> done at t+2.
        start = 1'b1; addr_in = 8'h10; we = 1'b0;
        tick();
        start = 1'b0;
        check("rd_req",  32'(bus.mem_req), 1);
        check("rd_busy", 32'(busy), 1);
        check("rd_done_early", 32'(done), 0);
        check("rd_addr", 32'(bus.mem_addr), 'h10);
        check("rd_we",   32'(bus.mem_we), 0);
        bus.mem_ack = 1'b1; bus.mem_rdata = 8'hA5;
        tick();
        bus.mem_ack = 1'b0;
        check("rd_done", 32'(done), 1);
        check("rd_req_drop", 32'(bus.mem_req), 0);
        check("rd_mdr",  32'(mdr_out), 'hA5);
        check("rd_err",  32'(err), 0);
        tick();
        check("rd_done_pulse", 32'(done), 0);
        check("rd_idle", 32'(busy), 0);

        // Write 0x3C to 0x20, ack on third REQ cycle.
        start = 1'b1; we = 1'b1; addr_in = 8'h20; wdata = 8'h3C;
        tick();
        start = 1'b0; we = 1'b0; wdata = 8'h00;
        check("wr_req",   32'(bus.mem_req), 1);
        check("wr_we",    32'(bus.mem_we), 1);
        check("wr_wdata", 32'(bus.mem_wdata), 'h3C);
        check("wr_addr",  32'(bus.mem_addr), 'h20);
        tick();
        check("wr_req_c2", 32'(bus.mem_req), 1);
        tick();
        check("wr_req_c3", 32'(bus.mem_req), 1);
        check("wr_we_c3",  32'(bus.mem_we), 1);
        bus.mem_ack = 1'b1; bus.mem_rdata = 8'hEE;
        tick();
        bus.mem_ack = 1'b0;
        check("wr_done", 32'(done), 1);
        check("wr_mdr",  32'(mdr_out), 'hA5);
        check("wr_err",  32'(err), 0);
        check("wr_req_drop", 32'(bus.mem_req), 0);
        tick();

        // Out of range (0xC8 = 200 = DEPTH).
        start = 1'b1; addr_in = 8'hC8;
        tick();
        start = 1'b0;
        check("rng_req",  32'(bus.mem_req), 0);
        check("rng_done", 32'(done), 1);
        check("rng_err",  32'(err), 1);
        check("rng_mar",  32'(mar_out), 'hC8);
        tick();
        check("rng_done_pulse", 32'(done), 0);
        check("rng_err_hold",   32'(err), 1);

        // Timeout: never ack, mem_req high for 4 cycles.
        start = 1'b1; addr_in = 8'h30;
        tick();
        start = 1'b0;
        check("to_err_clear", 32'(err), 0);
        for (int i = 0; i < 4; i++) begin
            check("to_req_high", 32'(bus.mem_req), 1);
            check("to_not_done", 32'(done), 0);
            tick();
        end
        check("to_req_drop", 32'(bus.mem_req), 0);
        check("to_done", 32'(done), 1);
        check("to_err",  32'(err), 2);
        check("to_mdr",  32'(mdr_out), 'hA5);
        tick();
        check("to_err_hold", 32'(err), 2);

        // Ack on the edge that would time out wins.
        start = 1'b1; addr_in = 8'h40;
        tick();
        start = 1'b0;
        repeat (3) tick();
        check("edge_req_c4", 32'(bus.mem_req), 1);
        bus.mem_ack = 1'b1; bus.mem_rdata = 8'h5A;
        tick();
        bus.mem_ack = 1'b0;
        check("edge_done", 32'(done), 1);
        check("edge_err",  32'(err), 0);
        check("edge_mdr",  32'(mdr_out), 'h5A);
        tick();

        // Ack outside REQ is ignored.
        bus.mem_ack = 1'b1; bus.mem_rdata = 8'hFF;
        tick();
        tick();
        bus.mem_ack = 1'b0;
        check("stray_mdr",  32'(mdr_out), 'h5A);
        check("stray_busy", 32'(busy), 0);

        // Auto-increment wraps DEPTH-1 -> 0, then 0 -> 1.
        start = 1'b1; addr_in = 8'hC7;
        tick();
        start = 1'b0;
        bus.mem_ack = 1'b1; bus.mem_rdata = 8'h11;
        tick();
        bus.mem_ack = 1'b0;
        tick();
        check("inc_mar_last", 32'(mar_out), 'hC7);
        check("inc_mdr_last", 32'(mdr_out), 'h11);
        start = 1'b1; incr = 1'b1; addr_in = 8'h55;
        tick();
        start = 1'b0; incr = 1'b0;
        check("inc_wrap_mar",  32'(mar_out), 0);
        check("inc_wrap_addr", 32'(bus.mem_addr), 0);
        check("inc_wrap_req",  32'(bus.mem_req), 1);
        bus.mem_ack = 1'b1; bus.mem_rdata = 8'h22;
        tick();
        bus.mem_ack = 1'b0;
        check("inc_wrap_mdr", 32'(mdr_out), 'h22);
        tick();
        start = 1'b1; incr = 1'b1;
        tick();
        start = 1'b0; incr = 1'b0;
        check("inc_next_mar", 32'(mar_out), 1);
        bus.mem_ack = 1'b1; bus.mem_rdata = 8'h33;
        tick();
        bus.mem_ack = 1'b0;
        check("inc_next_mdr", 32'(mdr_out), 'h33);
        tick();

        // start held through REQ and DONE starts nothing new.
        start = 1'b1; addr_in = 8'h50;
        tick();
        addr_in = 8'h60;
        bus.mem_ack = 1'b1; bus.mem_rdata = 8'h44;
        tick();
        bus.mem_ack = 1'b0;
        check("hold_done", 32'(done), 1);
        check("hold_mdr",  32'(mdr_out), 'h44);
        tick();
        start = 1'b0;
        check("hold_idle_busy", 32'(busy), 0);
        check("hold_idle_req",  32'(bus.mem_req), 0);
        check("hold_idle_done", 32'(done), 0);
        tick();
        check("hold_busy2", 32'(busy), 0);
        check("hold_mar",   32'(mar_out), 'h50);

        // Async reset mid-REQ.
        start = 1'b1; addr_in = 8'h60;
        tick();
        start = 1'b0;
        check("arst_pre_req", 32'(bus.mem_req), 1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_req",  32'(bus.mem_req), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_mar",  32'(mar_out), 0);
        check("arst_mdr",  32'(mdr_out), 0);
        check("arst_err",  32'(err), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        check("arst_after_busy", 32'(busy), 0);
        check("arst_after_req",  32'(bus.mem_req), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
